// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES decryption core: one inverse round per clock, round keys fetched by index.
// The GF(2^8) helpers and the three combinational inverse-round stages live in this file too.
package aes_inv_gf_pkg;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse, and it maps 0 to 0 as the S-box needs
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] b;
        b = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

endpackage

module aes_inv_shift_rows (
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);
    // Row r of the column-major state rotates right by r columns
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign data_o[8*(4*c+r) +: 8] = data_i[8*(4*((c-r+4)%4)+r) +: 8];
        end
    end
endmodule

module aes_inv_sub_bytes (
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);
    import aes_inv_gf_pkg::*;
    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign data_o[8*i +: 8] = inv_sbox(data_i[8*i +: 8]);
    end
endmodule

module aes_inv_mix_columns (
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);
    import aes_inv_gf_pkg::*;
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = data_i[32*c +: 8];
        assign a1 = data_i[32*c+8 +: 8];
        assign a2 = data_i[32*c+16 +: 8];
        assign a3 = data_i[32*c+24 +: 8];
        assign data_o[32*c +: 8]    = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        assign data_o[32*c+8 +: 8]  = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        assign data_o[32*c+16 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        assign data_o[32*c+24 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
endmodule

module aes_inv_round_ctrl #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    input  logic         abort,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

    localparam logic [3:0] NR_L = 4'(NR);

    state_e       state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] st_q, st_d;
    logic [127:0] isr, isb, ark, imc;
    logic         accept;

    aes_inv_shift_rows  u_isr (.data_i(st_q), .data_o(isr));
    aes_inv_sub_bytes   u_isb (.data_i(isr),  .data_o(isb));
    assign ark = isb ^ rk_data;
    aes_inv_mix_columns u_imc (.data_i(ark),  .data_o(imc));

    assign accept    = in_valid & in_ready;
    assign out_block = st_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            st_q    <= st_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        st_d    = st_q;
        if (abort) begin
            // Cancel wins over any acceptance; an idle block has nothing to cancel
            if (state_q != IDLE) begin
                state_d = IDLE;
                rnd_d   = '0;
                st_d    = '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = ROUND;
                        rnd_d   = NR_L - 4'd1;
                        st_d    = in_block ^ rk_data;
                    end
                end
                ROUND: begin
                    st_d  = imc;
                    rnd_d = rnd_q - 4'd1;
                    if (rnd_q == 4'd1) state_d = FINAL;
                end
                FINAL: begin
                    st_d    = ark;
                    state_d = DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        if (accept) begin
                            state_d = ROUND;
                            rnd_d   = NR_L - 4'd1;
                            st_d    = in_block ^ rk_data;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // in_ready is gated by rst_n so it reads 0 throughout reset
    always_comb begin
        in_ready  = 1'b0;
        rk_idx    = NR_L;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE:  in_ready = rst_n;
            ROUND: begin
                rk_idx = rnd_q;
                busy   = 1'b1;
            end
            FINAL: begin
                rk_idx = 4'd0;
                busy   = 1'b1;
            end
            DONE: begin
                in_ready  = rst_n & out_ready;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Scoreboarded bench for aes_inv_round_ctrl: FIPS-197 vectors, back-to-back, backpressure,
// abort and reset on an NR=10 instance, plus the AES-256 vector on an NR=14 instance.
module tb_aes_inv_round_ctrl;

    typedef struct {
        logic [127:0] pt;
        int           acc;
    } exp_t;

    logic clk, rst_n;
    logic iv10, ir10, ov10, ordy10, ab10, bz10;
    logic [127:0] ib10, rkd10, ob10;
    logic [3:0] rki10;
    logic iv14, ir14, ov14, ordy14, ab14, bz14;
    logic [127:0] ib14, rkd14, ob14;
    logic [3:0] rki14;

    logic [127:0] rk_tab [0:2][0:15];
    logic [1:0] off_key, act_key;
    exp_t q10[$];
    exp_t q14[$];
    int cyc, n_tot, n_pass;
    logic ov10_q, ov14_q;

    // Byte strings written MSB-first as in FIPS-197, byte 0 moved to bits [7:0]
    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_inv_round_ctrl #(.NR(10)) u10 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv10), .in_ready(ir10), .in_block(ib10),
        .rk_idx(rki10), .rk_data(rkd10), .out_valid(ov10), .out_ready(ordy10),
        .out_block(ob10), .abort(ab10), .busy(bz10));

    aes_inv_round_ctrl #(.NR(14)) u14 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv14), .in_ready(ir14), .in_block(ib14),
        .rk_idx(rki14), .rk_data(rkd14), .out_valid(ov14), .out_ready(ordy14),
        .out_block(ob14), .abort(ab14), .busy(bz14));

    // Index NR is only requested while accepting, so the offered block's key is used there
    assign rkd10 = rk_tab[(rki10 == 4'd10) ? off_key : act_key][rki10];
    assign rkd14 = rk_tab[2][rki14];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] brev(input logic [127:0] x);
        logic [127:0] y;
        for (int i = 0; i < 16; i++) y[8*i +: 8] = x[127-8*i -: 8];
        return y;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
        logic [15:0] t;
        t = {b, b} << k;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = 8'h01;
        for (int i = 0; i < 254; i++) b = gmul(b, x);
        if (x == 8'h00) b = 8'h00;
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    task automatic expand(input logic [255:0] key, input int nk, input int nr, input int sel);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rk_tab[sel][r] = brev({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic fail(input string nm);
        n_tot++;
        $display("FAIL %s: bound expired", nm);
    endtask

    // Offer a block, push its expected plaintext at the accept edge, return that edge number
    task automatic send(input bit w14, input logic [127:0] ct, input logic [127:0] pt,
                        input logic [1:0] key, output int acc);
        int n;
        exp_t e;
        @(posedge clk); #1;
        if (w14) begin iv14 = 1'b1; ib14 = ct; end
        else begin iv10 = 1'b1; ib10 = ct; off_key = key; end
        n = 0;
        @(negedge clk);
        while (!(w14 ? ir14 : ir10) && n < 60) begin @(negedge clk); n++; end
        acc = -1;
        if (!(w14 ? ir14 : ir10)) begin
            fail("accept");
            iv10 = 1'b0; iv14 = 1'b0;
            return;
        end
        chk("rk_idx_at_accept", {124'd0, w14 ? rki14 : rki10}, w14 ? 128'd14 : 128'd10);
        acc = cyc + 1;
        e.pt = pt;
        e.acc = acc;
        if (w14) q14.push_back(e); else q10.push_back(e);
        @(posedge clk); #1;
        if (w14) begin iv14 = 1'b0; ib14 = ~ct; end
        else begin iv10 = 1'b0; ib10 = ~ct; act_key = key; end
    endtask

    task automatic drain(input bit w14);
        int n;
        n = 0;
        while ((w14 ? q14.size() : q10.size()) != 0 && n < 80) begin @(posedge clk); n++; end
        if ((w14 ? q14.size() : q10.size()) != 0) begin
            fail(w14 ? "drain14" : "drain10");
            q10.delete(); q14.delete();
        end
        #1;
    endtask

    task automatic quiet10(input string nm);
        int seen;
        seen = 0;
        repeat (15) begin @(negedge clk); if (ov10) seen++; end
        chk(nm, 128'(seen), 128'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (ov10 && !ov10_q) begin
                if (q10.size() == 0) begin n_tot++; $display("FAIL out_valid10: got 1 with nothing pending, expected 0"); end
                else chk("latency10", 128'(cyc - q10[0].acc), 128'd10);
            end
            if (ov10 && ordy10 && q10.size() != 0) begin
                e = q10.pop_front();
                chk("plaintext10", ob10, e.pt);
            end
        end
        ov10_q <= ov10;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (ov14 && !ov14_q) begin
                if (q14.size() == 0) begin n_tot++; $display("FAIL out_valid14: got 1 with nothing pending, expected 0"); end
                else chk("latency14", 128'(cyc - q14[0].acc), 128'd14);
            end
            if (ov14 && ordy14 && q14.size() != 0) begin
                e = q14.pop_front();
                chk("plaintext14", ob14, e.pt);
            end
        end
        ov14_q <= ov14;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, n;
        cyc = 0; n_tot = 0; n_pass = 0;
        rst_n = 1'b0;
        iv10 = 1'b0; ib10 = '0; ordy10 = 1'b1; ab10 = 1'b0;
        iv14 = 1'b0; ib14 = '0; ordy14 = 1'b1; ab14 = 1'b0;
        off_key = 2'd0; act_key = 2'd0;
        expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10, 0);
        expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10, 1);
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14, 2);

        // Reset values
        #3;
        chk("reset_in_ready", {127'd0, ir10}, 128'd0);
        chk("reset_out_valid", {127'd0, ov10}, 128'd0);
        chk("reset_busy", {127'd0, bz10}, 128'd0);
        chk("reset_rk_idx", {124'd0, rki10}, 128'd10);
        chk("reset_out_block", ob10, 128'd0);
        chk("reset_rk_idx14", {124'd0, rki14}, 128'd14);
        #9 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", {127'd0, ir10}, 128'd1);

        // C.1 vector with the full round-key index walk
        send(1'b0, brev(C1_CT), brev(C1_PT), 2'd0, a1);
        for (int k = 9; k >= 0; k--) begin
            @(negedge clk);
            chk("rk_idx_walk", {124'd0, rki10}, 128'(k));
        end
        drain(1'b0);

        // Back-to-back: second block offered while the first is in flight
        send(1'b0, brev(C1_CT), brev(C1_PT), 2'd0, a1);
        send(1'b0, brev(B_CT), brev(B_PT), 2'd1, a2);
        chk("b2b_spacing", 128'(a2 - a1), 128'd11);
        drain(1'b0);

        // Backpressure: five stalled DONE cycles
        ordy10 = 1'b0;
        send(1'b0, brev(C1_CT), brev(C1_PT), 2'd0, a1);
        n = 0;
        while (!ov10 && n < 30) begin @(negedge clk); n++; end
        if (!ov10) fail("backpressure_wait");
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("bp_out_valid", {127'd0, ov10}, 128'd1);
            chk("bp_out_block", ob10, brev(C1_PT));
            chk("bp_in_ready", {127'd0, ir10}, 128'd0);
        end
        @(posedge clk); #1 ordy10 = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", {127'd0, ov10}, 128'd0);
        drain(1'b0);

        // Abort at rnd=5, then a clean C.1 run
        send(1'b0, brev(C1_CT), brev(C1_PT), 2'd0, a1);
        n = 0;
        @(negedge clk);
        while (!(bz10 && rki10 == 4'd5) && n < 20) begin @(negedge clk); n++; end
        if (!(bz10 && rki10 == 4'd5)) fail("abort_wait");
        ab10 = 1'b1;
        @(posedge clk); #1 ab10 = 1'b0;
        q10.delete();
        chk("abort_busy", {127'd0, bz10}, 128'd0);
        chk("abort_in_ready", {127'd0, ir10}, 128'd1);
        quiet10("abort_no_out_valid");
        send(1'b0, brev(C1_CT), brev(C1_PT), 2'd0, a1);
        drain(1'b0);

        // Abort beats acceptance in the same cycle
        @(posedge clk); #1;
        ab10 = 1'b1; iv10 = 1'b1; ib10 = brev(C1_CT);
        @(posedge clk); #1;
        ab10 = 1'b0; iv10 = 1'b0;
        chk("abort_over_accept", {127'd0, bz10}, 128'd0);

        // Asynchronous reset mid-ROUND
        send(1'b0, brev(C1_CT), brev(C1_PT), 2'd0, a1);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        q10.delete();
        chk("rst_out_valid", {127'd0, ov10}, 128'd0);
        chk("rst_busy", {127'd0, bz10}, 128'd0);
        chk("rst_in_ready", {127'd0, ir10}, 128'd0);
        chk("rst_rk_idx", {124'd0, rki10}, 128'd10);
        chk("rst_out_block", ob10, 128'd0);
        #12 rst_n = 1'b1;
        quiet10("rst_no_out_valid");

        // AES-256 on the NR=14 instance
        send(1'b1, brev(C3_CT), brev(C1_PT), 2'd2, a1);
        for (int k = 13; k >= 0; k--) begin
            @(negedge clk);
            chk("rk_idx_walk14", {124'd0, rki14}, 128'(k));
        end
        drain(1'b1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
